// File: rtl/fft_seq_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fft_seq_ctrl_if                                                  |
// | Host / MC-FIFO / datapath handshake bundle for fft_seq_ctrl.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface fft_seq_ctrl_if #(
  parameter int LOG2N = 10,
  parameter int SIG_W = 18
);
  logic                           startF;
  logic                           startI;
  logic                           filter;
  logic [SIG_W-1:0]               sigNum;
  logic                           loadInFifo;
  logic                           loadExternalDone;
  logic                           accelWrBlkDone;
  logic [SIG_W-1:0]               sigNumMC;
  logic                           calculating;
  logic                           inFifoReady;
  logic                           loadExternal;
  logic                           loadInternal;
  logic [$clog2(2*LOG2N+1)-1:0]   stageCount;
  logic [LOG2N-2:0]               cycleCount;
  logic                           ifftMode;
  logic                           filterPass;
  logic                           doneCalculating;
  logic                           loadOutBuffer;
  logic                           outFifoReady;
  logic                           done;
  logic                           startErr;

  // Controller side
  modport slave (
    input  startF, startI, filter, sigNum, loadInFifo, loadExternalDone, accelWrBlkDone,
    output sigNumMC, calculating, inFifoReady, loadExternal, loadInternal, stageCount,
           cycleCount, ifftMode, filterPass, doneCalculating, loadOutBuffer, outFifoReady,
           done, startErr
  );

  // Host / datapath side
  modport master (
    output startF, startI, filter, sigNum, loadInFifo, loadExternalDone, accelWrBlkDone,
    input  sigNumMC, calculating, inFifoReady, loadExternal, loadInternal, stageCount,
           cycleCount, ifftMode, filterPass, doneCalculating, loadOutBuffer, outFifoReady,
           done, startErr
  );
endinterface
`default_nettype wire

// File: rtl/fft_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fft_seq_ctrl                                                     |
// | Sequencer for FFT / IFFT / fused FFT-filter-IFFT runs: counts MC |
// | beats, requests RAM load, steps stage/cycle counters, drives the |
// | out-buffer load and the block-ready handshake. Moore outputs.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fft_seq_ctrl #(
  parameter int LOG2N = 10,
  parameter int BEATS = 128,
  parameter int SIG_W = 18
) (
  input  logic          clk,
  input  logic          rst,
  fft_seq_ctrl_if.slave bus
);
  localparam int N       = 1 << LOG2N;
  localparam int HALF    = N / 2;
  localparam int STAGE_W = $clog2(2*LOG2N+1);
  localparam int CYC_W   = LOG2N - 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS-1);
  localparam logic [CYC_W-1:0]   LAST_CYC   = CYC_W'(HALF-1);
  localparam logic [LOG2N-1:0]   LAST_OUT   = LOG2N'(N-1);
  localparam logic [STAGE_W-1:0] FWD_LAST   = STAGE_W'(LOG2N-1);
  localparam logic [STAGE_W-1:0] FILT_STAGE = STAGE_W'(LOG2N);
  localparam logic [STAGE_W-1:0] FILT_LAST  = STAGE_W'(2*LOG2N);

  typedef enum logic [2:0] {
    IDLE, FILL, LOAD_RAM, CALC, CALC_END, LOAD_OUT, OUT_WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {MODE_FFT, MODE_IFFT, MODE_FILTER} mode_t;

  typedef struct packed {
    logic calculating;
    logic in_fifo_ready;
    logic load_external;
    logic load_internal;
    logic ifft_mode;
    logic filter_pass;
    logic done_calculating;
    logic load_out_buffer;
    logic out_fifo_ready;
    logic done;
    logic start_err;
  } flags_t;

  state_t              state, state_nxt;
  mode_t               mode, mode_nxt;
  logic [SIG_W-1:0]    sig_num, sig_nxt;
  logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
  logic [LOG2N-1:0]    out_cnt, out_nxt;
  logic [STAGE_W-1:0]  stage, stage_nxt;
  logic [CYC_W-1:0]    cycle, cycle_nxt;
  flags_t              flags, flags_nxt;
  logic [STAGE_W-1:0]  last_stage;

  assign last_stage = (mode == MODE_FILTER) ? FILT_LAST : FWD_LAST;

  // State, counters and registered output flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      mode     <= MODE_FFT;
      sig_num  <= '0;
      beat_cnt <= '0;
      out_cnt  <= '0;
      stage    <= '0;
      cycle    <= '0;
      flags    <= '0;
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      sig_num  <= sig_nxt;
      beat_cnt <= beat_nxt;
      out_cnt  <= out_nxt;
      stage    <= stage_nxt;
      cycle    <= cycle_nxt;
      flags    <= flags_nxt;
    end
  end

  // Next-state, counter stepping and next output flags decoded from the next state
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    sig_nxt   = sig_num;
    beat_nxt  = beat_cnt;
    out_nxt   = out_cnt;
    stage_nxt = stage;
    cycle_nxt = cycle;
    flags_nxt = '0;

    case (state)
      IDLE: begin
        if (bus.startF ^ bus.startI) begin
          state_nxt = FILL;
          sig_nxt   = bus.sigNum;
          beat_nxt  = '0;
          mode_nxt  = bus.startI ? MODE_IFFT : (bus.filter ? MODE_FILTER : MODE_FFT);
        end
      end
      FILL: begin
        if (bus.loadInFifo) begin
          if (beat_cnt == LAST_BEAT) state_nxt = LOAD_RAM;
          else                       beat_nxt  = beat_cnt + BEAT_W'(1);
        end
      end
      LOAD_RAM: begin
        // Completion only counts once the load request is actually on the wire
        if (flags.load_external && bus.loadExternalDone) begin
          state_nxt = CALC;
          stage_nxt = '0;
          cycle_nxt = '0;
        end
      end
      CALC: begin
        if (cycle == LAST_CYC) begin
          cycle_nxt = '0;
          if (stage == last_stage) begin
            state_nxt = CALC_END;
            stage_nxt = '0;
          end else begin
            stage_nxt = stage + STAGE_W'(1);
          end
        end else begin
          cycle_nxt = cycle + CYC_W'(1);
        end
      end
      CALC_END: begin
        state_nxt = LOAD_OUT;
        out_nxt   = '0;
      end
      LOAD_OUT: begin
        if (out_cnt == LAST_OUT) state_nxt = OUT_WAIT;
        else                     out_nxt   = out_cnt + LOG2N'(1);
      end
      OUT_WAIT: begin
        if (bus.accelWrBlkDone) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    flags_nxt.start_err        = (bus.startF & bus.startI) |
                                 ((bus.startF | bus.startI) & (state != IDLE));
    flags_nxt.calculating      = (state_nxt != IDLE) && (state_nxt != DONE);
    flags_nxt.in_fifo_ready    = (state_nxt == LOAD_RAM);
    flags_nxt.load_external    = (state == LOAD_RAM) && (state_nxt == LOAD_RAM);
    flags_nxt.load_internal    = (state_nxt == CALC);
    flags_nxt.ifft_mode        = (state_nxt == CALC) &&
                                 ((mode_nxt == MODE_IFFT) ||
                                  ((mode_nxt == MODE_FILTER) && (stage_nxt > FILT_STAGE)));
    flags_nxt.filter_pass      = (state_nxt == CALC) && (mode_nxt == MODE_FILTER) &&
                                 (stage_nxt == FILT_STAGE);
    flags_nxt.done_calculating = (state_nxt == CALC_END);
    flags_nxt.load_out_buffer  = (state_nxt == LOAD_OUT);
    flags_nxt.out_fifo_ready   = (state_nxt == OUT_WAIT);
    flags_nxt.done             = (state_nxt == DONE);
  end

  assign bus.sigNumMC        = sig_num;
  assign bus.calculating     = flags.calculating;
  assign bus.inFifoReady     = flags.in_fifo_ready;
  assign bus.loadExternal    = flags.load_external;
  assign bus.loadInternal    = flags.load_internal;
  assign bus.stageCount      = stage;
  assign bus.cycleCount      = cycle;
  assign bus.ifftMode        = flags.ifft_mode;
  assign bus.filterPass      = flags.filter_pass;
  assign bus.doneCalculating = flags.done_calculating;
  assign bus.loadOutBuffer   = flags.load_out_buffer;
  assign bus.outFifoReady    = flags.out_fifo_ready;
  assign bus.done            = flags.done;
  assign bus.startErr        = flags.start_err;
endmodule
`default_nettype wire

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Parametrised sequencing controller for the FFT accelerator: supports FFT, IFFT and a fused FFT→filter→IFFT mode. It counts inbound memory-controller beats and hands RAM loading to the datapath. It then steps stage/cycle counters through every butterfly pass, drives the out-buffer load, and holds the block-ready handshake with the host. It sits between the MC interface FIFOs and the butterfly/RAM datapath; it contains no sample datapath.

## Interface
- LOG2N, 10, log2 of transform points (legal 3..12); N = 2**LOG2N, butterflies per stage = N/2
- BEATS, 128, MC beats per input block (legal 1..4096)
- SIG_W, 18, signal-number width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-low (rst=0 at a rising edge resets)
- startF  in  1  start FFT (with filter=1: start fused filter run)
- startI  in  1  start IFFT
- filter  in  1  qualifies startF; sampled only with the accepted start
- sigNum  in  SIG_W  signal number, captured on accepted start
- loadInFifo  in  1  one valid MC beat this cycle
- loadExternalDone  in  1  datapath finished RAM load from in FIFO
- accelWrBlkDone  in  1  host finished draining out FIFO
- sigNumMC  out  SIG_W  captured signal number
- calculating  out  1  high from accepted start until done
- inFifoReady  out  1  BEATS beats received
- loadExternal  out  1  RAM load request
- loadInternal  out  1  butterfly pass active
- stageCount  out  $clog2(2*LOG2N+1)  global stage index
- cycleCount  out  LOG2N-1  butterfly index within stage
- ifftMode  out  1  current stage uses inverse twiddles
- filterPass  out  1  filter-multiply pass active
- doneCalculating  out  1  one-cycle pulse after last pass
- loadOutBuffer  out  1  RAM→out FIFO transfer active
- outFifoReady  out  1  out FIFO full, awaiting host
- done  out  1  one-cycle completion pulse
- startErr  out  1  one-cycle pulse: start rejected

## Operation
- States: IDLE, FILL, LOAD_RAM, CALC, CALC_END, LOAD_OUT, OUT_WAIT, DONE.
- IDLE: startF xor startI accepted → FILL; capture sigNum; mode = IFFT if startI, FILTER if startF&filter, else FFT.
- startF&startI together, or any start outside IDLE: ignored, startErr pulses, state unchanged.
- FILL: beat counter increments per loadInFifo; beat BEATS-1 accepted → LOAD_RAM with inFifoReady=1. loadInFifo outside FILL ignored.
- LOAD_RAM: loadExternal=1; on loadExternalDone=1 (loadExternal still 1 that cycle) → CALC with stage=0, cycle=0.
- CALC: loadInternal=1; cycleCount 0..N/2-1, wraps to 0 and stageCount+1. Last stage index: LOG2N-1 (FFT/IFFT), 2*LOG2N (FILTER).
- FILTER mode: stages 0..LOG2N-1 forward; stage LOG2N filterPass=1; stages LOG2N+1..2*LOG2N ifftMode=1. IFFT mode: ifftMode=1 all stages.
- CALC_END: one cycle, loadInternal=0, doneCalculating=1 → LOAD_OUT.
- LOAD_OUT: loadOutBuffer=1 for exactly N cycles → OUT_WAIT.
- OUT_WAIT: outFifoReady=1 until accelWrBlkDone=1 → DONE.
- DONE: done=1, calculating=0 → IDLE; start accepted from the following cycle.
- Reset: all outputs 0, sigNumMC=0, counters 0, state IDLE, regardless of state; takes effect at the reset edge.

## Timing
- All outputs registered (Moore); start at edge k → sigNumMC, calculating valid after edge k.
- inFifoReady rises at the edge accepting the last beat; loadExternal rises at the next edge.
- CALC cycles: (LOG2N)*(N/2) for FFT/IFFT, (2*LOG2N+1)*(N/2) for FILTER.
- Total start→done latency, FFT with zero-wait handshakes: 1 + BEATS + 1 + LOG2N*N/2 + 1 + N + 1 + 1 cycles.
- loadExternalDone or accelWrBlkDone asserted before their state: ignored, not latched.

## Test plan
- LOG2N=10, BEATS=128: startF, sigNum=1, 128 beats, loadExternalDone after 20 cycles → 10×512 CALC cycles with matching stage/cycle, doneCalculating pulse, loadOutBuffer 1024 cycles, outFifoReady until accelWrBlkDone, done 1 cycle.
- LOG2N=3, startF+filter: stages 0–2 ifftMode=0, stage 3 filterPass=1, stages 4–6 ifftMode=1, 4 cycles each, 28 CALC cycles total.
- startI, sigNum=0x3FFFF: sigNumMC=0x3FFFF, ifftMode=1 every CALC cycle.
- startF&startI together in IDLE → startErr pulse, state IDLE; startF during CALC → startErr, counters undisturbed.
- Gapped loadInFifo (every 3rd cycle) → inFifoReady only after 128th beat; stray loadInFifo in CALC → no effect.
- rst=0 mid-CALC (stage 5, cycle 200) → next cycle all outputs 0; fresh startF runs full sequence correctly.
